// File: rtl/wb_trap_commit.sv
// Writeback/commit stage: registers RF/CSR writes, branch redirects and retire count, and
// sequences trap entry (mepc, mcause, mtval writes, then redirect to mtvec).
module wb_trap_commit #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned CNT_W       = 64,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             WB_V,
    input  logic [31:0]      WB_IR,
    input  logic [XLEN-1:0]  WB_PC,
    input  logic [XLEN-1:0]  WB_NPC,
    input  logic [XLEN-1:0]  WB_ALU_RESULT,
    input  logic [XLEN-1:0]  WB_MEM_RESULT,
    input  logic [XLEN-1:0]  WB_RFD,
    input  logic [XLEN-1:0]  WB_CSRFD,
    input  logic [4:0]       WB_DRID,
    input  logic             WB_PC_MUX,
    input  logic [7:0]       WB_EXC,
    input  logic [XLEN-1:0]  WB_TVAL,
    input  logic             TIMER,
    input  logic             EXTERNAL,
    input  logic             MIE,
    input  logic [XLEN-1:0]  MTVEC,
    output logic [XLEN-1:0]  WB_RF_DATA,
    output logic [4:0]       WB_DRID_OUT,
    output logic             WB_LD_REG,
    output logic [XLEN-1:0]  WB_CSR_DATA,
    output logic [11:0]      WB_CSR_ADDR,
    output logic             WB_ST_CSR,
    output logic             PC_MUX,
    output logic [XLEN-1:0]  WB_BR_JMP_TARGET,
    output logic             WB_FLUSH,
    output logic             WB_STALL,
    output logic [XLEN-1:0]  WB_CAUSE,
    output logic [CNT_W-1:0] WB_INSTRET
);

    typedef enum logic [2:0] {StRun, StSaveEpc, StSaveCause, StSaveTval, StRedirect} state_e;

    state_e          state_q;
    logic [XLEN-1:0] epc_q, tval_q, target_q;

    logic            trap_exc, trap_irq;
    logic [3:0]      exc_code;
    logic [XLEN-1:0] trap_cause, trap_target, rf_sel;
    logic            rf_we, csr_we;
    logic            unused_ir;

    assign unused_ir = ^{WB_IR[19:15], WB_IR[11:7]};

    always_comb begin
        trap_exc = |WB_EXC;
        trap_irq = !trap_exc && MIE && (EXTERNAL || TIMER);

        if      (WB_EXC[0]) exc_code = 4'd1;
        else if (WB_EXC[1]) exc_code = 4'd0;
        else if (WB_EXC[2]) exc_code = 4'd2;
        else if (WB_EXC[3]) exc_code = 4'd11;
        else if (WB_EXC[4]) exc_code = 4'd6;
        else if (WB_EXC[5]) exc_code = 4'd4;
        else if (WB_EXC[6]) exc_code = 4'd7;
        else                exc_code = 4'd5;

        if (trap_irq) trap_cause = {1'b1, {(XLEN-5){1'b0}}, EXTERNAL ? 4'd11 : 4'd7};
        else          trap_cause = {{(XLEN-4){1'b0}}, exc_code};

        // Vectored mode offsets by 4*cause code with the interrupt bit dropped.
        trap_target = {MTVEC[XLEN-1:2], 2'b00};
        if (VECTORED_EN && (MTVEC[1:0] == 2'b01) && trap_irq) begin
            trap_target = trap_target + {trap_cause[XLEN-3:0], 2'b00};
        end

        rf_we  = 1'b1;
        csr_we = 1'b0;
        rf_sel = '0;
        case (WB_IR[6:0])
            7'b0000011: rf_sel = WB_MEM_RESULT;
            7'b0010011, 7'b0110011, 7'b0011011,
            7'b0111011, 7'b0110111, 7'b0010111: rf_sel = WB_ALU_RESULT;
            7'b1101111, 7'b1100111: rf_sel = WB_NPC;
            7'b1110011: begin
                if (WB_IR[14:12] != 3'b000) begin
                    rf_sel = WB_RFD;
                    csr_we = 1'b1;
                end else begin
                    rf_we = 1'b0;
                end
            end
            default: rf_we = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q          <= StRun;
            epc_q            <= '0;
            tval_q           <= '0;
            target_q         <= '0;
            WB_RF_DATA       <= '0;
            WB_DRID_OUT      <= '0;
            WB_LD_REG        <= 1'b0;
            WB_CSR_DATA      <= '0;
            WB_CSR_ADDR      <= '0;
            WB_ST_CSR        <= 1'b0;
            PC_MUX           <= 1'b0;
            WB_BR_JMP_TARGET <= '0;
            WB_FLUSH         <= 1'b0;
            WB_STALL         <= 1'b0;
            WB_CAUSE         <= '0;
            WB_INSTRET       <= '0;
        end else begin
            WB_LD_REG <= 1'b0;
            WB_ST_CSR <= 1'b0;
            PC_MUX    <= 1'b0;
            WB_FLUSH  <= 1'b0;
            case (state_q)
                StRun: begin
                    WB_STALL <= 1'b0;
                    if (WB_V && (trap_exc || trap_irq)) begin
                        WB_FLUSH <= 1'b1;
                        WB_STALL <= 1'b1;
                        WB_CAUSE <= trap_cause;
                        epc_q    <= WB_PC;
                        tval_q   <= trap_exc ? WB_TVAL : '0;
                        target_q <= trap_target;
                        state_q  <= StSaveEpc;
                    end else if (WB_V) begin
                        WB_RF_DATA       <= rf_sel;
                        WB_DRID_OUT      <= WB_DRID;
                        WB_LD_REG        <= rf_we && (WB_DRID != 5'd0);
                        if (csr_we) begin
                            WB_ST_CSR   <= 1'b1;
                            WB_CSR_ADDR <= WB_IR[31:20];
                            WB_CSR_DATA <= WB_CSRFD;
                        end
                        PC_MUX           <= WB_PC_MUX;
                        WB_BR_JMP_TARGET <= WB_ALU_RESULT;
                        WB_INSTRET       <= WB_INSTRET + CNT_W'(1);
                    end
                end
                StSaveEpc: begin
                    WB_ST_CSR   <= 1'b1;
                    WB_CSR_ADDR <= 12'h341;
                    WB_CSR_DATA <= epc_q;
                    state_q     <= StSaveCause;
                end
                StSaveCause: begin
                    WB_ST_CSR   <= 1'b1;
                    WB_CSR_ADDR <= 12'h342;
                    WB_CSR_DATA <= WB_CAUSE;
                    state_q     <= StSaveTval;
                end
                StSaveTval: begin
                    WB_ST_CSR   <= 1'b1;
                    WB_CSR_ADDR <= 12'h343;
                    WB_CSR_DATA <= tval_q;
                    state_q     <= StRedirect;
                end
                StRedirect: begin
                    PC_MUX           <= 1'b1;
                    WB_BR_JMP_TARGET <= target_q;
                    WB_STALL         <= 1'b0;
                    state_q          <= StRun;
                end
                default: begin
                    WB_STALL <= 1'b0;
                    state_q  <= StRun;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_trap_commit.sv
// Randomised scoreboard bench for wb_trap_commit: a driver pushes expected per-cycle outputs
// from a reference model, a monitor pops and compares one record after each clock edge.
module tb_wb_trap_commit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        WB_V = 1'b0;
    logic [31:0] WB_IR = '0;
    logic [63:0] WB_PC = '0, WB_NPC = '0, WB_ALU_RESULT = '0, WB_MEM_RESULT = '0;
    logic [63:0] WB_RFD = '0, WB_CSRFD = '0, WB_TVAL = '0, MTVEC = '0;
    logic [4:0]  WB_DRID = '0;
    logic        WB_PC_MUX = 1'b0;
    logic [7:0]  WB_EXC = '0;
    logic        TIMER = 1'b0, EXTERNAL = 1'b0, MIE = 1'b0;
    logic [63:0] WB_RF_DATA, WB_CSR_DATA, WB_BR_JMP_TARGET, WB_CAUSE;
    logic [4:0]  WB_DRID_OUT;
    logic        WB_LD_REG, WB_ST_CSR, PC_MUX, WB_FLUSH, WB_STALL;
    logic [11:0] WB_CSR_ADDR;
    logic [3:0]  WB_INSTRET;

    always #5 CLK = ~CLK;

    wb_trap_commit #(.XLEN(64), .CNT_W(4), .VECTORED_EN(1'b1)) dut (
        .CLK(CLK), .RESET(RESET), .WB_V(WB_V), .WB_IR(WB_IR), .WB_PC(WB_PC), .WB_NPC(WB_NPC),
        .WB_ALU_RESULT(WB_ALU_RESULT), .WB_MEM_RESULT(WB_MEM_RESULT), .WB_RFD(WB_RFD),
        .WB_CSRFD(WB_CSRFD), .WB_DRID(WB_DRID), .WB_PC_MUX(WB_PC_MUX), .WB_EXC(WB_EXC),
        .WB_TVAL(WB_TVAL), .TIMER(TIMER), .EXTERNAL(EXTERNAL), .MIE(MIE), .MTVEC(MTVEC),
        .WB_RF_DATA(WB_RF_DATA), .WB_DRID_OUT(WB_DRID_OUT), .WB_LD_REG(WB_LD_REG),
        .WB_CSR_DATA(WB_CSR_DATA), .WB_CSR_ADDR(WB_CSR_ADDR), .WB_ST_CSR(WB_ST_CSR),
        .PC_MUX(PC_MUX), .WB_BR_JMP_TARGET(WB_BR_JMP_TARGET), .WB_FLUSH(WB_FLUSH),
        .WB_STALL(WB_STALL), .WB_CAUSE(WB_CAUSE), .WB_INSTRET(WB_INSTRET)
    );

    typedef struct packed {
        logic        rst, v;
        logic [31:0] ir;
        logic [63:0] pc, npc, alu, mem, rfd, csrfd, tval, mtvec;
        logic [4:0]  drid;
        logic        pcmux;
        logic [7:0]  exc;
        logic        timer, ext, mie;
    } stim_t;

    typedef struct packed {
        logic        ld;
        logic [4:0]  drid;
        logic [63:0] rf;
        logic        st;
        logic [11:0] ca;
        logic [63:0] cd;
        logic        pm;
        logic [63:0] tg;
        logic        fl, stl;
        logic [63:0] cause;
        logic [3:0]  inst;
    } exp_t;

    // Cause code per flag bit; bit order is also priority order (bit0 highest).
    localparam int PRIO_CODE [8] = '{1, 0, 2, 11, 6, 4, 7, 5};
    localparam logic [6:0] OPS [12] = '{7'h03, 7'h13, 7'h33, 7'h1b, 7'h3b, 7'h37, 7'h17,
                                        7'h6f, 7'h67, 7'h73, 7'h23, 7'h63};
    localparam logic [63:0] IRQ_BIT = 64'h8000_0000_0000_0000;

    exp_t        sb[$];
    exp_t        pend[$];
    logic [63:0] m_cause = '0;
    logic [3:0]  m_inst = '0;
    int          n_chk = 0, n_pass = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
        n_chk++;
        if (a !== x) $display("FAIL %s: got %h expected %h", n, a, x);
        else n_pass++;
    endtask

    task automatic model(input stim_t s, output exp_t e);
        exp_t        r;
        logic [63:0] c, tgt, val;
        logic        irq, wr, csr;
        e = '0;
        if (s.rst) begin
            pend.delete();
            m_cause = '0;
            m_inst  = '0;
            return;
        end
        if (pend.size() > 0) begin
            e = pend.pop_front();
            return;
        end
        e.cause = m_cause;
        e.inst  = m_inst;
        if (!s.v) return;
        irq = (s.exc == 8'd0) && s.mie && (s.ext || s.timer);
        if (s.exc != 8'd0 || irq) begin
            c = '0;
            for (int i = 7; i >= 0; i--) if (s.exc[i]) c = 64'(PRIO_CODE[i]);
            if (irq) c = IRQ_BIT + (s.ext ? 64'd11 : 64'd7);
            tgt = s.mtvec - (s.mtvec % 64'd4);
            if (irq && (s.mtvec % 64'd4) == 64'd1) tgt = tgt + 64'd4 * (c - IRQ_BIT);
            m_cause = c;
            r       = '0;
            r.cause = c;
            r.inst  = m_inst;
            e       = r;
            e.fl    = 1'b1;
            e.stl   = 1'b1;
            r.stl   = 1'b1;
            r.st    = 1'b1;
            r.ca = 12'h341; r.cd = s.pc;                 pend.push_back(r);
            r.ca = 12'h342; r.cd = c;                    pend.push_back(r);
            r.ca = 12'h343; r.cd = irq ? 64'd0 : s.tval; pend.push_back(r);
            r.st = 1'b0; r.ca = '0; r.cd = '0; r.stl = 1'b0;
            r.pm = 1'b1; r.tg = tgt;                     pend.push_back(r);
            return;
        end
        wr  = 1'b1;
        csr = 1'b0;
        val = '0;
        case (s.ir[6:0])
            7'h03: val = s.mem;
            7'h13, 7'h33, 7'h1b, 7'h3b, 7'h37, 7'h17: val = s.alu;
            7'h6f, 7'h67: val = s.npc;
            7'h73: begin
                wr  = (s.ir[14:12] != 3'd0);
                csr = wr;
                val = s.rfd;
            end
            default: wr = 1'b0;
        endcase
        m_inst = m_inst + 4'd1;
        e.ld   = wr && (s.drid != 5'd0);
        e.drid = s.drid;
        e.rf   = val;
        e.st   = csr;
        e.ca   = s.ir[31:20];
        e.cd   = s.csrfd;
        e.pm   = s.pcmux;
        e.tg   = s.alu;
        e.inst = m_inst;
    endtask

    task automatic drive(input stim_t s);
        exp_t e;
        @(negedge CLK);
        RESET = s.rst; WB_V = s.v; WB_IR = s.ir; WB_PC = s.pc; WB_NPC = s.npc;
        WB_ALU_RESULT = s.alu; WB_MEM_RESULT = s.mem; WB_RFD = s.rfd; WB_CSRFD = s.csrfd;
        WB_TVAL = s.tval; MTVEC = s.mtvec; WB_DRID = s.drid; WB_PC_MUX = s.pcmux;
        WB_EXC = s.exc; TIMER = s.timer; EXTERNAL = s.ext; MIE = s.mie;
        model(s, e);
        sb.push_back(e);
    endtask

    function automatic stim_t idle();
        stim_t s = '0;
        s.mtvec = 64'h2000;
        return s;
    endfunction

    function automatic stim_t addi(input logic [4:0] rd, input logic [63:0] res);
        stim_t s = idle();
        s.v = 1'b1; s.ir = 32'h02A0_0013 | (32'(rd) << 7); s.drid = rd; s.alu = res;
        s.pc = 64'h1000;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s       = '0;
        s.rst   = ($urandom_range(0, 99) == 0);
        s.v     = ($urandom_range(0, 3) != 0);
        s.ir    = $urandom;
        s.ir[6:0] = OPS[$urandom_range(0, 11)];
        s.pc    = {$urandom, $urandom}; s.npc = {$urandom, $urandom};
        s.alu   = {$urandom, $urandom}; s.mem = {$urandom, $urandom};
        s.rfd   = {$urandom, $urandom}; s.csrfd = {$urandom, $urandom};
        s.tval  = {$urandom, $urandom};
        s.mtvec = {$urandom, $urandom};
        s.drid  = 5'($urandom);
        s.pcmux = 1'($urandom);
        s.exc   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'd0;
        s.timer = ($urandom_range(0, 7) == 0);
        s.ext   = ($urandom_range(0, 7) == 0);
        s.mie   = 1'($urandom);
        return s;
    endfunction

    // Monitor: one expected record per clock edge, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ld_reg", 64'(WB_LD_REG), 64'(e.ld));
                chk("st_csr", 64'(WB_ST_CSR), 64'(e.st));
                chk("pc_mux", 64'(PC_MUX), 64'(e.pm));
                chk("flush", 64'(WB_FLUSH), 64'(e.fl));
                chk("stall", 64'(WB_STALL), 64'(e.stl));
                chk("cause", WB_CAUSE, e.cause);
                chk("instret", 64'(WB_INSTRET), 64'(e.inst));
                if (e.ld) begin
                    chk("drid", 64'(WB_DRID_OUT), 64'(e.drid));
                    chk("rf_data", WB_RF_DATA, e.rf);
                end
                if (e.st) begin
                    chk("csr_addr", 64'(WB_CSR_ADDR), 64'(e.ca));
                    chk("csr_data", WB_CSR_DATA, e.cd);
                end
                if (e.pm) chk("target", WB_BR_JMP_TARGET, e.tg);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        stim_t s;
        s = idle(); s.rst = 1'b1;
        drive(s); drive(s);
        drive(idle());
        // ADDI x5 -> 0x2A
        drive(addi(5'd5, 64'h2A));
        // LW to x0
        s = idle(); s.v = 1'b1; s.ir = 32'h0000_2003; s.mem = 64'h1234; drive(s);
        // JAL x1
        s = idle(); s.v = 1'b1; s.ir = 32'h0000_00EF; s.drid = 5'd1; s.npc = 64'h104;
        s.alu = 64'h200; s.pcmux = 1'b1; drive(s);
        // CSRRW x3
        s = idle(); s.v = 1'b1; s.ir = 32'h3400_11F3; s.drid = 5'd3; s.rfd = 64'h77;
        s.csrfd = 64'h99; drive(s);
        // II|LAM exception, then stalled cycles whose WB_V is ignored
        s = addi(5'd7, 64'h55); s.exc = 8'b0010_0100; s.pc = 64'h80; s.tval = 64'hDEAD;
        s.mtvec = 64'h3001; drive(s);
        for (int i = 0; i < 4; i++) drive(addi(5'd8, 64'h66));
        drive(addi(5'd9, 64'h11));
        // Both interrupts pending, vectored mtvec
        s = addi(5'd7, 64'h55); s.mie = 1'b1; s.timer = 1'b1; s.ext = 1'b1;
        s.mtvec = 64'h1001; drive(s);
        for (int i = 0; i < 4; i++) drive(idle());
        s = addi(5'd7, 64'h55); s.mie = 1'b1; s.timer = 1'b1; s.mtvec = 64'h1001; drive(s);
        for (int i = 0; i < 4; i++) drive(idle());
        // Interrupts masked
        s = addi(5'd4, 64'h31); s.timer = 1'b1; drive(s);
        // Reset during SAVE_CAUSE
        s = addi(5'd7, 64'h55); s.exc = 8'h08; s.pc = 64'h400; drive(s);
        drive(idle());
        s = idle(); s.rst = 1'b1; drive(s);
        drive(idle()); drive(idle());
        // 16 retires wrap the 4-bit counter
        for (int i = 0; i < 16; i++) drive(addi(5'(i + 1), 64'(i)));
        drive(idle());
        for (int i = 0; i < 400; i++) drive(rnd());
        drive(idle());
        repeat (3) @(negedge CLK);
        chk("drain", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
